m_usequencer: RTL and testbench

- Microcode sequencer directly upstream of the microcode store wrapper.
- Computes the next microcode index `minx` from the store's `rinx` output, the opcode dispatch index and branch condition, plus reset, interrupt and bus-error redirects.
- Generates `progress_ucode`, which freezes the registered microcode word during shift sequences and memory wait states.
- Owns the shift-step counter (controlled by sa19:sa18) and a bus wait-state timeout.

---
 rtl/m_usequencer.sv | 80 ++++++++
 tb/tb_m_usequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/m_usequencer.sv
// m_usequencer: next microcode index selection, store clock enable, shift-step counter and bus wait timeout.
module m_usequencer #(
    parameter logic [7:0]  RESET_UADR   = 8'h00,
    parameter logic [7:0]  IRQ_UADR     = 8'h02,
    parameter logic [7:0]  BUSERR_UADR  = 8'h04,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rinx,
    input  logic [7:0] dinx,
    input  logic       use_dinx,
    input  logic       use_brcond,
    input  logic       brcond,
    input  logic       sa18,
    input  logic       sa19,
    input  logic [4:0] shamt,
    input  logic       stall,
    input  logic       irq_take,
    output logic [7:0] minx,
    output logic       progress_ucode,
    output logic       shcnt_zero,
    output logic       bus_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;
    state_t     r_state;
    logic [4:0] r_shcnt;
    logic [7:0] r_wcnt;
    logic       w_sa_load;
    logic       w_sa_dec;
    logic       w_shift_go;
    logic       w_fire;
    assign w_sa_load  = {sa19, sa18} == 2'b01;
    assign w_sa_dec   = {sa19, sa18} == 2'b10;
    assign w_shift_go = r_state == IDLE && w_sa_load && shamt != 5'd0;
    assign w_fire     = r_state == WAIT && WAIT_TIMEOUT != 0 && r_wcnt == 8'(WAIT_TIMEOUT) && stall;
    assign bus_err    = w_fire && !rst;
    assign shcnt_zero = r_shcnt == 5'd0;
    always_comb begin
        minx = rst ? RESET_UADR :
               w_fire ? BUSERR_UADR :
               use_dinx ? (irq_take ? IRQ_UADR : dinx) :
               {rinx[7:1], rinx[0] | (use_brcond & brcond)};
        // a shift load takes precedence over a stall in the same IDLE cycle
        progress_ucode = rst ? 1'b1 :
                         r_state == SHIFT ? r_shcnt == 5'd1 :
                         r_state == WAIT ? (!stall || w_fire) :
                         !(w_shift_go || stall);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shcnt <= 5'd0;
            r_wcnt  <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sa_load) r_shcnt <= shamt;
                    else if (w_sa_dec && r_shcnt != 5'd0) r_shcnt <= r_shcnt - 5'd1;
                    if (w_shift_go) r_state <= SHIFT;
                    else if (stall) begin
                        r_state <= WAIT;
                        r_wcnt  <= 8'd1;
                    end
                end
                SHIFT: begin
                    r_shcnt <= r_shcnt - 5'd1;
                    if (r_shcnt == 5'd1) r_state <= IDLE;
                end
                WAIT: begin
                    if (!stall || w_fire) begin
                        r_state <= IDLE;
                        r_wcnt  <= 8'd0;
                    end else if (r_wcnt != 8'hFF) r_wcnt <= r_wcnt + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_usequencer.sv
// tb_m_usequencer: directed vector table plus multi-cycle shift, wait, timeout and reset sequences.
module tb_m_usequencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] rinx = 8'h00, dinx = 8'h00;
    logic       use_dinx = 1'b0, use_brcond = 1'b0, brcond = 1'b0;
    logic       sa18 = 1'b0, sa19 = 1'b0, stall = 1'b0, irq_take = 1'b0;
    logic [4:0] shamt = 5'd0;
    logic [7:0] minx;
    logic       progress_ucode, shcnt_zero, bus_err;
    int checks = 0, errors = 0;

    typedef struct {
        logic [7:0] rinx;
        logic [7:0] dinx;
        logic       use_dinx;
        logic       use_brcond;
        logic       brcond;
        logic       irq_take;
        logic [7:0] exp_minx;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    m_usequencer #(.WAIT_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .rinx(rinx), .dinx(dinx), .use_dinx(use_dinx),
        .use_brcond(use_brcond), .brcond(brcond), .sa18(sa18), .sa19(sa19),
        .shamt(shamt), .stall(stall), .irq_take(irq_take), .minx(minx),
        .progress_ucode(progress_ucode), .shcnt_zero(shcnt_zero), .bus_err(bus_err)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pe(input string tag, input logic p, input logic e);
        #2;
        chk({tag, " progress"}, {7'd0, progress_ucode}, {7'd0, p});
        chk({tag, " bus_err"}, {7'd0, bus_err}, {7'd0, e});
    endtask

    task automatic set_sa(input logic [1:0] sa, input logic [4:0] amt);
        {sa19, sa18} = sa;
        shamt = amt;
    endtask

    initial begin
        tbl[0] = '{8'h40, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h41};
        tbl[1] = '{8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40};
        tbl[2] = '{8'h40, 8'h9C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h9C};
        tbl[3] = '{8'h40, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02};
        tbl[4] = '{8'h40, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40};
        tbl[5] = '{8'h7E, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E};
        tbl[6] = '{8'h55, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55};

        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            rinx = 8'($urandom); dinx = 8'($urandom);
            use_dinx = 1'($urandom); use_brcond = 1'($urandom); brcond = 1'($urandom);
            sa18 = 1'($urandom); sa19 = 1'($urandom); shamt = 5'($urandom);
            stall = 1'($urandom); irq_take = 1'($urandom);
            expect_pe("reset", 1'b1, 1'b0);
            chk("reset minx", minx, 8'h00);
            tick();
        end
        rst = 1'b0;
        rinx = 8'h10; dinx = 8'h00; use_dinx = 1'b0; use_brcond = 1'b0; brcond = 1'b0;
        set_sa(2'b00, 5'd0); stall = 1'b0; irq_take = 1'b0;
        expect_pe("post reset", 1'b1, 1'b0);
        chk("post reset shcnt_zero", {7'd0, shcnt_zero}, 8'd1);
        chk("post reset minx", minx, 8'h10);
        tick();

        for (int i = 0; i < 7; i++) begin
            rinx = tbl[i].rinx; dinx = tbl[i].dinx; use_dinx = tbl[i].use_dinx;
            use_brcond = tbl[i].use_brcond; brcond = tbl[i].brcond; irq_take = tbl[i].irq_take;
            expect_pe($sformatf("vec%0d", i), 1'b1, 1'b0);
            chk($sformatf("vec%0d minx", i), minx, tbl[i].exp_minx);
            tick();
        end
        rinx = 8'h20; use_dinx = 1'b0; use_brcond = 1'b0; brcond = 1'b0; irq_take = 1'b0;

        set_sa(2'b01, 5'd5);
        for (int i = 0; i < 6; i++) begin
            expect_pe($sformatf("shift5 c%0d", i), i == 5, 1'b0);
            chk($sformatf("shift5 c%0d shcnt_zero", i), {7'd0, shcnt_zero}, {7'd0, i == 0});
            tick();
        end
        set_sa(2'b00, 5'd0);
        expect_pe("shift5 done", 1'b1, 1'b0);
        chk("shift5 done shcnt_zero", {7'd0, shcnt_zero}, 8'd1);
        tick();

        set_sa(2'b01, 5'd0);
        expect_pe("shift0", 1'b1, 1'b0);
        chk("shift0 minx", minx, 8'h20);
        tick();
        set_sa(2'b00, 5'd0);
        expect_pe("shift0 next", 1'b1, 1'b0);
        tick();

        set_sa(2'b01, 5'd2); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_pe($sformatf("shift2 stall c%0d", i), i == 2, 1'b0);
            tick();
        end
        set_sa(2'b00, 5'd0);
        expect_pe("stall after shift", 1'b0, 1'b0);
        tick();
        stall = 1'b0;
        expect_pe("stall after shift release", 1'b1, 1'b0);
        tick();

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_pe($sformatf("wait c%0d", i), 1'b0, 1'b0);
            tick();
        end
        stall = 1'b0;
        expect_pe("wait release", 1'b1, 1'b0);
        tick();
        expect_pe("wait idle", 1'b1, 1'b0);
        chk("wait idle minx", minx, 8'h20);
        tick();

        stall = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            expect_pe($sformatf("timeout c%0d", i), i == 5 || i == 10, i == 5 || i == 10);
            if (i == 5) chk("timeout minx", minx, 8'h04);
            tick();
        end
        stall = 1'b0;
        expect_pe("timeout release", 1'b1, 1'b0);
        tick();

        set_sa(2'b01, 5'd5);
        for (int i = 0; i < 3; i++) tick();
        expect_pe("mid shift", 1'b0, 1'b0);
        chk("mid shift shcnt_zero", {7'd0, shcnt_zero}, 8'd0);
        rst = 1'b1;
        expect_pe("mid shift rst", 1'b1, 1'b0);
        chk("mid shift rst minx", minx, 8'h00);
        tick();
        rst = 1'b0;
        set_sa(2'b00, 5'd0);
        expect_pe("after shift rst", 1'b1, 1'b0);
        chk("after shift rst shcnt_zero", {7'd0, shcnt_zero}, 8'd1);
        chk("after shift rst minx", minx, 8'h20);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
